// File: rtl/smoldvi_deserialiser.sv
// smoldvi_deserialiser: TMDS lane word aligner, hunts control tokens to find the 10-bit boundary.
// Optional SMOLDVI_DESER_STATS_EN adds slip_count and lock_lost outputs.
module smoldvi_deserialiser #(
    parameter int LOCK_COUNT = 8,
    parameter int W_TIMEOUT  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_rise,
    input  logic       d_fall,
    output logic [9:0] q,
    output logic       q_valid,
    output logic       q_ctrl,
    output logic       locked
`ifdef SMOLDVI_DESER_STATS_EN
    ,
    output logic [7:0] slip_count,
    output logic       lock_lost
`endif
);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic   [11:1]          sr_q;
    logic   [2:0]           phase_q, phase_d;
    logic                   off_q, stall_q;
    logic   [W_TIMEOUT-1:0] tcnt_q;
    logic   [CW-1:0]        ccnt_q, ccnt_d;
    logic   [9:0]           q_q, w;
    logic                   q_valid_q, q_ctrl_q;
    logic                   cap, tok, sat, slip;

    assign cap = phase_q == 3'd4 && !stall_q;
    assign w   = off_q ? sr_q[10:1] : sr_q[11:2];
    assign tok = w inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    assign sat = &tcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        if (cap) begin
            case (state_q)
                HUNT: if (tok) begin
                    ccnt_d  = CW'(1);
                    state_d = LOCK_COUNT == 1 ? LOCKED : CHECK;
                end
                CHECK: if (tok) begin
                    ccnt_d  = ccnt_q + CW'(1);
                    state_d = ccnt_d == CW'(LOCK_COUNT) ? LOCKED : CHECK;
                end else begin
                    ccnt_d  = '0;
                    state_d = HUNT;
                end
                LOCKED:  state_d = !tok && sat ? HUNT : LOCKED;
                default: state_d = HUNT;
            endcase
        end
    end

    // A token always wins over a timeout; CHECK slips on any non-token word.
    always_comb begin
        slip   = cap && !tok && (state_q == CHECK || sat);
        locked = state_q == LOCKED;
    end

    // Slipping from off=0 to off=1 needs 11 bits, so phase 4 is held one extra cycle.
    assign phase_d = (slip && !off_q) ? 3'd4 : phase_q == 3'd4 ? 3'd0 : phase_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            phase_q   <= '0;
            off_q     <= 1'b0;
            stall_q   <= 1'b0;
            tcnt_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_ctrl_q  <= 1'b0;
        end else begin
            sr_q      <= {d_fall, d_rise, sr_q[11:3]};
            phase_q   <= phase_d;
            off_q     <= off_q ^ slip;
            stall_q   <= slip && !off_q;
            q_valid_q <= cap;
            if (cap) begin
                tcnt_q   <= tok ? '0 : tcnt_q + W_TIMEOUT'(1);
                q_q      <= w;
                q_ctrl_q <= tok;
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_ctrl  = q_ctrl_q;

`ifdef SMOLDVI_DESER_STATS_EN
    logic [7:0] slip_cnt_q;
    logic       lock_lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_cnt_q  <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            if (slip && slip_cnt_q != 8'hFF) slip_cnt_q <= slip_cnt_q + 8'd1;
            lock_lost_q <= state_q == LOCKED && state_d == HUNT;
        end
    end

    assign slip_count = slip_cnt_q;
    assign lock_lost  = lock_lost_q;
`endif
endmodule
